// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl
//   Issue/collect stage in front of the 32x32 signed Booth/CSA multiplier.
//   Requests {a, b, tag} are queued in a small FIFO. Each one is handed to the
//   multiplier with registered operands and a clean 0->1 start edge. The
//   product (or a timeout error) is returned on a valid/ready response port.
//   Only one multiply is outstanding at a time, and requests complete in order.
//
//   Ports
//     clk, rst_n                      clock, asynchronous active-low reset
//     req_valid/req_ready             request handshake; req_ready = !full
//     req_a, req_b, req_tag           signed operands and request tag
//     rsp_valid/rsp_ready             response handshake
//     rsp_product, rsp_tag, rsp_err   result (0 on error), tag, timeout flag
//     mul_start                       start to multiplier, high for one cycle
//     mul_operand_a/b                 operands, held from SETUP to end of RESP
//     mul_done, mul_product           multiplier completion pulse and result
//     busy                            FSM active or FIFO non-empty
//     fifo_level                      FIFO occupancy
//
//   Optional build macro MUL_ISSUE_STATS_EN adds the saturating counters
//   stat_ops (good responses) and stat_timeouts (error responses).
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for a queued request; pops head when non-empty
//   SETUP | operands loaded, mul_start held low for one cycle
//   FIRE  | mul_start high for one cycle
//   WAIT  | waiting for mul_done, timeout counter running
//   RESP  | response presented until rsp_ready

module mul_issue_ctrl #(
    parameter int FIFO_DEPTH  = 4,
    parameter int TAG_W       = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [31:0]                 req_a,
    input  logic [31:0]                 req_b,
    input  logic [TAG_W-1:0]            req_tag,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [63:0]                 rsp_product,
    output logic [TAG_W-1:0]            rsp_tag,
    output logic                        rsp_err,
    output logic                        mul_start,
    output logic [31:0]                 mul_operand_a,
    output logic [31:0]                 mul_operand_b,
    input  logic                        mul_done,
    input  logic [63:0]                 mul_product,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
`ifdef MUL_ISSUE_STATS_EN
    ,
    output logic [31:0]                 stat_ops,
    output logic [15:0]                 stat_timeouts
`endif
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int CNT_W   = $clog2(TIMEOUT_CYC);
    localparam int ENTRY_W = 64 + TAG_W;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_FIRE  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    state_t state, state_next;

    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   level_next;
    logic [ENTRY_W-1:0] head;
    logic               push;
    logic               pop;

    logic [CNT_W-1:0]   tmo_cnt;
    logic               tmo_expire;
    logic               start_next;
    logic               cap_ok;
    logic               cap_tmo;
    logic               rsp_hs;

    // ---------------- request FIFO ----------------
    assign push = req_valid && req_ready;
    assign head = fifo_mem[rd_ptr];

    always_comb begin
        level_next = fifo_level;
        if (push && !pop) begin
            level_next = fifo_level + 1'b1;
        end else if (!push && pop) begin
            level_next = fifo_level - 1'b1;
        end
    end

    // Payload storage needs no reset: level and pointers say what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {req_a, req_b, req_tag};
        end
    end

    // req_ready is registered from the next occupancy, so it equals !full
    // every cycle and comes up one cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            req_ready  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_level <= level_next;
            req_ready  <= (level_next != LVL_FULL);
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    assign tmo_expire = (tmo_cnt == '0);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (fifo_level != '0) state_next = ST_SETUP;
            ST_SETUP: state_next = ST_FIRE;
            ST_FIRE:  state_next = ST_WAIT;
            ST_WAIT:  if (mul_done || tmo_expire) state_next = ST_RESP;
            ST_RESP:  if (rsp_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // mul_done wins over a timeout that expires in the same cycle.
    always_comb begin
        pop        = (state == ST_IDLE) && (fifo_level != '0);
        start_next = (state_next == ST_FIRE);
        cap_ok     = (state == ST_WAIT) && mul_done;
        cap_tmo    = (state == ST_WAIT) && !mul_done && tmo_expire;
        rsp_hs     = (state == ST_RESP) && rsp_ready;
    end

    // Timeout is a down-counter loaded at pop; reaching zero in WAIT marks
    // the last of TIMEOUT_CYC waiting cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_start     <= 1'b0;
            mul_operand_a <= '0;
            mul_operand_b <= '0;
            tmo_cnt       <= '0;
            rsp_valid     <= 1'b0;
            rsp_product   <= '0;
            rsp_tag       <= '0;
            rsp_err       <= 1'b0;
            busy          <= 1'b0;
        end else begin
            mul_start <= start_next;
            busy      <= (state_next != ST_IDLE) || (level_next != '0);

            if (pop) begin
                mul_operand_a <= head[ENTRY_W-1 -: 32];
                mul_operand_b <= head[TAG_W +: 32];
                rsp_tag       <= head[TAG_W-1:0];
                tmo_cnt       <= TMO_LOAD;
            end else if (state == ST_WAIT && !tmo_expire) begin
                tmo_cnt <= tmo_cnt - 1'b1;
            end

            if (cap_ok) begin
                rsp_product <= mul_product;
                rsp_err     <= 1'b0;
                rsp_valid   <= 1'b1;
            end else if (cap_tmo) begin
                rsp_product <= '0;
                rsp_err     <= 1'b1;
                rsp_valid   <= 1'b1;
            end else if (rsp_hs) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef MUL_ISSUE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops      <= '0;
            stat_timeouts <= '0;
        end else if (rsp_hs) begin
            if (!rsp_err && stat_ops != '1) begin
                stat_ops <= stat_ops + 1'b1;
            end
            if (rsp_err && stat_timeouts != '1) begin
                stat_timeouts <= stat_timeouts + 1'b1;
            end
        end
    end
`endif

endmodule
